leaf_stream_packetizer: RTL and testbench

Transmit-side converter for a BFT leaf: accepts one 32-bit AXI-Stream output of a user kernel and emits 49-bit BFT packets on `dout_leaf_interface2bft`, addressed to a configured destination leaf/port. Credit-based flow control tracks free space in the destination's 128-entry receive BRAM; credits are restored by freespace-update pulses from the leaf's receive path. It sits between a kernel's `Output_x_V_*` stream and the BFT output of a leaf.

---
 rtl/bft_pkg.sv | 39 +++
 rtl/leaf_stream_packetizer_credit_counter.sv | 38 +++
 rtl/leaf_stream_packetizer.sv | 65 ++++++
 tb/tb_leaf_stream_packetizer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// bft_pkg: BFT packet layout, leaf-interface sizing and packet helper shared by the leaf RTL
package bft_pkg;
    localparam int PACKET_BITS           = 49;
    localparam int PAYLOAD_BITS          = 32;
    localparam int NUM_LEAF_BITS         = 4;
    localparam int NUM_PORT_BITS         = 4;
    localparam int NUM_ADDR_BITS         = 7;
    localparam int FREESPACE_UPDATE_SIZE = 64;
    localparam int VALID_BIT  = 48;
    localparam int LEAF_MSB   = 47;
    localparam int LEAF_LSB   = 44;
    localparam int PORT_MSB   = 43;
    localparam int PORT_LSB   = 40;
    localparam int TYPE_BIT   = 39;
    localparam int ADDR_MSB   = 38;
    localparam int ADDR_LSB   = 32;
    localparam logic TYPE_DATA = 1'b0;
    localparam int CREDIT_BITS = 8;
    localparam int CREDIT_MAX  = 1 << NUM_ADDR_BITS;

    typedef enum logic {UNCFG, RUN} state_e;

    function automatic logic [PACKET_BITS-1:0] make_packet(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  data
    );
        logic [PACKET_BITS-1:0] p;
        p = '0;
        p[VALID_BIT]         = 1'b1;
        p[LEAF_MSB:LEAF_LSB] = leaf;
        p[PORT_MSB:PORT_LSB] = port;
        p[TYPE_BIT]          = TYPE_DATA;
        p[ADDR_MSB:ADDR_LSB] = addr;
        p[PAYLOAD_BITS-1:0]  = data;
        return p;
    endfunction
endpackage

// File: rtl/leaf_stream_packetizer_credit_counter.sv
// credit_counter: saturating up/down credit counter with sticky overflow flag
module credit_counter #(
    parameter int W   = 8,
    parameter int MAX = 128,
    parameter int INC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] credit_o,
    output logic         err_o
);
    logic [W:0]   sum;
    logic [W-1:0] credit_q, credit_d;
    logic         err_q, err_d;

    // add a returned block, subtract an accepted word, clamp at the ceiling
    always_comb begin
        sum      = {1'b0, credit_q} + (inc_i ? (W+1)'(INC) : '0) - (W+1)'(dec_i);
        credit_d = (sum > (W+1)'(MAX)) ? W'(MAX) : sum[W-1:0];
        err_d    = err_q || (sum > (W+1)'(MAX));
    end

    // credit and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= W'(MAX);
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

    assign credit_o = credit_q;
    assign err_o    = err_q;
endmodule

// File: rtl/leaf_stream_packetizer.sv
// leaf_stream_packetizer: wraps a 32-bit AXI-Stream into credit-controlled BFT packets
module leaf_stream_packetizer
    import bft_pkg::*;
(
    input  logic                     clk,
    input  logic                     ap_rst_n,
    input  logic                     cfg_we,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
    input  logic [PAYLOAD_BITS-1:0]  Input_1_V_TDATA,
    input  logic                     Input_1_V_TVALID,
    output logic                     Input_1_V_TREADY,
    input  logic                     freespace_update,
    input  logic                     resend,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    output logic                     credit_err
);
    state_e                   state_q;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] port_q;
    logic [NUM_ADDR_BITS-1:0] addr_q;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic [CREDIT_BITS-1:0]   credit;
    logic                     accept;

    assign Input_1_V_TREADY = (state_q == RUN) && (credit != '0) && !resend;
    assign accept           = Input_1_V_TVALID && Input_1_V_TREADY;

    credit_counter #(
        .W  (CREDIT_BITS),
        .MAX(CREDIT_MAX),
        .INC(FREESPACE_UPDATE_SIZE)
    ) u_cc (
        .clk     (clk),
        .rst_n   (ap_rst_n),
        .inc_i   (freespace_update),
        .dec_i   (accept),
        .credit_o(credit),
        .err_o   (credit_err)
    );

    // next output word: hold on resend, packet on accept, idle zeros otherwise
    always_comb dout_d = resend ? dout_q : accept ? make_packet(leaf_q, port_q, addr_q, Input_1_V_TDATA) : '0;

    // FSM, destination latch, address counter and output register
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= UNCFG;
            leaf_q  <= '0;
            port_q  <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
        end else begin
            if (cfg_we) begin
                state_q <= RUN;
                leaf_q  <= cfg_dst_leaf;
                port_q  <= cfg_dst_port;
            end
            if (accept) addr_q <= addr_q + 1'b1;
            dout_q <= dout_d;
        end
    end

    assign dout_leaf_interface2bft = dout_q;
endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// tb_leaf_stream_packetizer: directed self-checking bench for the leaf packetizer
module tb_leaf_stream_packetizer;
    logic        clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_dst_leaf = '0;
    logic [3:0]  cfg_dst_port = '0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        freespace_update = 1'b0;
    logic        resend = 1'b0;
    logic [48:0] dout;
    logic        credit_err;
    int          n_checks = 0;
    int          n_err = 0;

    leaf_stream_packetizer dut (
        .clk                    (clk),
        .ap_rst_n               (ap_rst_n),
        .cfg_we                 (cfg_we),
        .cfg_dst_leaf           (cfg_dst_leaf),
        .cfg_dst_port           (cfg_dst_port),
        .Input_1_V_TDATA        (tdata),
        .Input_1_V_TVALID       (tvalid),
        .Input_1_V_TREADY       (tready),
        .freespace_update       (freespace_update),
        .resend                 (resend),
        .dout_leaf_interface2bft(dout),
        .credit_err             (credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [48:0] exp_pkt(input logic [3:0] lf, input logic [3:0] pt, input logic [6:0] a, input logic [31:0] d);
        return {1'b1, lf, pt, 1'b0, a, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        #3;
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic configure(input logic [3:0] lf, input logic [3:0] pt);
        cfg_we = 1'b1;
        cfg_dst_leaf = lf;
        cfg_dst_port = pt;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic stream(input int n, input logic [31:0] base, input logic [6:0] a0, input logic [3:0] lf, input logic [3:0] pt);
        for (int i = 0; i < n; i++) begin
            tvalid = 1'b1;
            tdata = base + 32'(i);
            #1;
            chk("stream_tready", 64'(tready), 64'd1);
            tick();
            chk("stream_dout", 64'(dout), 64'(exp_pkt(lf, pt, a0 + 7'(i), base + 32'(i))));
        end
        tvalid = 1'b0;
    endtask

    initial begin
        #12;
        ap_rst_n = 1'b1;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_credit", 64'(dut.u_cc.credit_q), 64'd128);
        tvalid = 1'b1;
        tdata = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("uncfg_tready", 64'(tready), 64'd0);
            chk("uncfg_dout", 64'(dout), 64'd0);
        end
        tvalid = 1'b0;
        configure(4'd5, 4'd2);
        stream(3, 32'hA, 7'd0, 4'd5, 4'd2);
        chk("three_credit", 64'(dut.u_cc.credit_q), 64'd125);
        tick();
        chk("idle_dout", 64'(dout), 64'd0);
        do_reset();
        configure(4'd5, 4'd2);
        stream(128, 32'h100, 7'd0, 4'd5, 4'd2);
        tvalid = 1'b1;
        tdata = 32'h999;
        #1;
        chk("empty_tready", 64'(tready), 64'd0);
        chk("empty_credit", 64'(dut.u_cc.credit_q), 64'd0);
        tick();
        chk("refused_dout", 64'(dout), 64'd0);
        freespace_update = 1'b1;
        tick();
        freespace_update = 1'b0;
        chk("update_credit", 64'(dut.u_cc.credit_q), 64'd64);
        stream(64, 32'h1000, 7'd0, 4'd5, 4'd2);
        tvalid = 1'b1;
        #1;
        chk("second_empty_tready", 64'(tready), 64'd0);
        tvalid = 1'b0;
        freespace_update = 1'b1;
        tick();
        freespace_update = 1'b0;
        stream(2, 32'h2000, 7'd64, 4'd5, 4'd2);
        resend = 1'b1;
        tvalid = 1'b1;
        tdata = 32'h2002;
        #1;
        chk("resend_tready", 64'(tready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("resend_hold", 64'(dout), 64'(exp_pkt(4'd5, 4'd2, 7'd65, 32'h2001)));
            chk("resend_tready_hold", 64'(tready), 64'd0);
        end
        resend = 1'b0;
        stream(2, 32'h2002, 7'd66, 4'd5, 4'd2);
        chk("credit_60", 64'(dut.u_cc.credit_q), 64'd60);
        tvalid = 1'b1;
        tdata = 32'h3000;
        freespace_update = 1'b1;
        tick();
        freespace_update = 1'b0;
        tvalid = 1'b0;
        chk("coinc_credit_123", 64'(dut.u_cc.credit_q), 64'd123);
        chk("coinc_no_err", 64'(credit_err), 64'd0);
        chk("coinc_dout", 64'(dout), 64'(exp_pkt(4'd5, 4'd2, 7'd68, 32'h3000)));
        stream(23, 32'h4000, 7'd69, 4'd5, 4'd2);
        chk("credit_100", 64'(dut.u_cc.credit_q), 64'd100);
        tvalid = 1'b1;
        tdata = 32'h5000;
        freespace_update = 1'b1;
        tick();
        freespace_update = 1'b0;
        tvalid = 1'b0;
        chk("sat_credit", 64'(dut.u_cc.credit_q), 64'd128);
        chk("sat_err", 64'(credit_err), 64'd1);
        chk("sat_dout", 64'(dout), 64'(exp_pkt(4'd5, 4'd2, 7'd92, 32'h5000)));
        tick();
        tick();
        chk("err_sticky", 64'(credit_err), 64'd1);
        do_reset();
        configure(4'd3, 4'd9);
        stream(40, 32'h6000, 7'd0, 4'd3, 4'd9);
        tvalid = 1'b1;
        tdata = 32'h7000;
        tick();
        chk("pre_reset_dout", 64'(dout), 64'(exp_pkt(4'd3, 4'd9, 7'd40, 32'h7000)));
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_dout", 64'(dout), 64'd0);
        chk("midrst_tready", 64'(tready), 64'd0);
        chk("midrst_credit", 64'(dut.u_cc.credit_q), 64'd128);
        #1;
        ap_rst_n = 1'b1;
        tick();
        chk("post_rst_uncfg", 64'(tready), 64'd0);
        chk("post_rst_dout", 64'(dout), 64'd0);
        tvalid = 1'b0;
        configure(4'd7, 4'd1);
        stream(1, 32'h8000, 7'd0, 4'd7, 4'd1);
        tvalid = 1'b1;
        tdata = 32'h8001;
        cfg_we = 1'b1;
        cfg_dst_leaf = 4'd4;
        cfg_dst_port = 4'd6;
        tick();
        cfg_we = 1'b0;
        chk("cfg_coinc_old_dst", 64'(dout), 64'(exp_pkt(4'd7, 4'd1, 7'd1, 32'h8001)));
        stream(1, 32'h8002, 7'd2, 4'd4, 4'd6);
        chk("final_credit", 64'(dut.u_cc.credit_q), 64'd125);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
